// File: rtl/ps2_keyboard_port_pkg.sv
// Shared types and register-map constants for the PS/2 keyboard port.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic PS2_REG_DATA   = 1'b0;
  localparam logic PS2_REG_STATUS = 1'b1;

  localparam int unsigned PS2_ST_NE   = 0;
  localparam int unsigned PS2_ST_OVF  = 1;
  localparam int unsigned PS2_ST_PERR = 2;

endpackage

// File: rtl/ps2_keyboard_port_receiver.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, frame FSM and
// inactivity timeout. Emits a one-cycle byteValid/parityFail when a frame ends.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       parityFail
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clkSync, dataSync;
  logic          clkPrev;
  logic          fall, bitIn, timeoutHit;
  ps2_state_t    state, stateNext;
  logic [2:0]    bitCnt, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          parityBit, parityNext;
  logic [TW-1:0] timer, timerNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkSync   <= '1;
      dataSync  <= '1;
      clkPrev   <= 1'b1;
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      timer     <= '0;
    end else begin
      clkSync   <= {clkSync[0], ps2Clk};
      dataSync  <= {dataSync[0], ps2Data};
      clkPrev   <= clkSync[1];
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      parityBit <= parityNext;
      timer     <= timerNext;
    end
  end

  assign fall       = clkPrev & ~clkSync[1];
  assign bitIn      = dataSync[1];
  assign timeoutHit = (state != IDLE) && (timer >= TW'(TIMEOUT_CYCLES - 1));

  // Outputs are combinational so the FIFO push lands on the edge that
  // consumes the stop-bit falling edge.
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    parityNext = parityBit;
    timerNext  = timer + 1'b1;
    byteValid  = 1'b0;
    parityFail = 1'b0;
    byteData   = shiftReg;
    if (fall || state == IDLE) timerNext = '0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!bitIn) begin
            stateNext  = DATA;
            bitCntNext = '0;
          end
        end
        DATA: begin
          shiftNext  = {bitIn, shiftReg[7:1]};
          bitCntNext = bitCnt + 1'b1;
          if (bitCnt == 3'd7) stateNext = PARITY;
        end
        PARITY: begin
          parityNext = bitIn;
          stateNext  = STOP;
        end
        STOP: begin
          if (bitIn) begin
            if (^{shiftReg, parityBit}) byteValid  = 1'b1;
            else                        parityFail = 1'b1;
          end
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end else if (timeoutHit) begin
      stateNext = IDLE;
    end
  end

endmodule

// File: rtl/ps2_keyboard_port.sv
// Memory-mapped PS/2 keyboard port: frame receiver feeding a scan-code FIFO,
// drained through DATA/STATUS words on data-memory bank 2.
module ps2_keyboard_port
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  output logic        kbdIrq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic          byteValid, parityFail;
  logic [7:0]    byteData;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;
  logic          overflow, parityErr;
  logic          notEmpty, full, pop, push, statusWr;
  logic [2:0]    statusBits;
  logic          unusedBits;

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) receiver (
    .clk       (clk),
    .rst       (rst),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .byteValid (byteValid),
    .byteData  (byteData),
    .parityFail(parityFail)
  );

  assign notEmpty = (count != '0);
  assign full     = (count == (PW + 1)'(FIFO_DEPTH));
  assign pop      = en && (memWrite == 4'b0) && (addr[0] == PS2_REG_DATA) && notEmpty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign push     = byteValid && (!full || pop);
  assign statusWr = en && (memWrite != 4'b0) && (addr[0] == PS2_REG_STATUS);
  assign kbdIrq   = notEmpty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      if (byteValid && full && !pop)           overflow <= 1'b1;
      else if (statusWr && wdata[PS2_ST_OVF])  overflow <= 1'b0;
      if (parityFail)                          parityErr <= 1'b1;
      else if (statusWr && wdata[PS2_ST_PERR]) parityErr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= byteData;
  end

  always_comb begin
    statusBits              = '0;
    statusBits[PS2_ST_NE]   = notEmpty;
    statusBits[PS2_ST_OVF]  = overflow;
    statusBits[PS2_ST_PERR] = parityErr;
    rdata                   = '0;
    if (addr[0] == PS2_REG_STATUS)
      rdata = {16'b0, 8'(count), 5'b0, statusBits};
    else if (notEmpty)
      rdata = {24'b0, mem[rdPtr]};
  end

  assign unusedBits = ^{addr[10:1], wdata[31:3], wdata[0]};

endmodule
